// File: rtl/mult_div_unit_pkg.sv
// Shared encodings, default latencies and result types for the multiply/divide unit.
package mult_div_unit_pkg;

    // md_op encodings
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Default busy latencies
    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    // Full 64-bit multiply result
    typedef logic [63:0] md_result_t;

    // HI/LO pair as produced by an operation
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multi-cycle multiply/divide unit owning the HI/LO registers.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        wr_hilo,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0]  count;
    logic [31:0]       hi_tmp;
    logic [31:0]       lo_tmp;
    logic              div_zero;

    logic signed [63:0] a_sx_c;
    logic signed [63:0] b_sx_c;
    logic signed [32:0] dvd_s_c;
    logic signed [32:0] dvs_s_c;
    logic [31:0]        dvs_u_c;
    md_result_t         prod_c;
    hilo_t              result_c;
    logic               div_zero_c;
    logic               is_div_c;
    logic               op_valid_c;

    // Result of the E-stage operands for whichever arithmetic op is presented.
    // Dividends/divisors use 33 bits so 0x80000000 / -1 yields 0x80000000 without overflow,
    // and a zero divisor is replaced by 1 so the (discarded) result is never X.
    always_comb begin
        a_sx_c     = {{32{A[31]}}, A};
        b_sx_c     = {{32{B[31]}}, B};
        div_zero_c = (B == 32'd0);
        dvd_s_c    = {A[31], A};
        dvs_s_c    = div_zero_c ? 33'sd1 : {B[31], B};
        dvs_u_c    = div_zero_c ? 32'd1 : B;
        prod_c     = '0;
        result_c   = '0;
        is_div_c   = 1'b0;
        op_valid_c = 1'b1;
        case (md_op)
            MD_MULT: begin
                prod_c   = md_result_t'(a_sx_c * b_sx_c);
                result_c = prod_c;
            end
            MD_MULTU: begin
                prod_c   = {32'd0, A} * {32'd0, B};
                result_c = prod_c;
            end
            MD_DIV: begin
                is_div_c    = 1'b1;
                result_c.lo = 32'(dvd_s_c / dvs_s_c);
                result_c.hi = 32'(dvd_s_c % dvs_s_c);
            end
            MD_DIVU: begin
                is_div_c    = 1'b1;
                result_c.lo = A / dvs_u_c;
                result_c.hi = A % dvs_u_c;
            end
            default: op_valid_c = 1'b0;
        endcase
    end

    // Accept/countdown/complete sequencing plus MTHI/MTLO writes into HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            count    <= '0;
            hi_tmp   <= '0;
            lo_tmp   <= '0;
            div_zero <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else if (busy) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                busy <= 1'b0;
                if (!div_zero) begin
                    HI <= hi_tmp;
                    LO <= lo_tmp;
                end
            end
        end else if (start && !cancel) begin
            if (op_valid_c) begin
                busy     <= 1'b1;
                count    <= is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                hi_tmp   <= result_c.hi;
                lo_tmp   <= result_c.lo;
                div_zero <= is_div_c && div_zero_c;
            end
        end else if (!start && wr_hilo && !cancel) begin
            if (md_op == MD_MTHI) begin
                HI <= A;
            end else if (md_op == MD_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected HI/LO/latency,
// a negedge monitor compares on every busy 1->0 transition.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        wr_hilo;
    logic        cancel;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors    = 0;
    int   checks    = 0;
    int   busy_len  = 0;
    logic busy_prev = 1'b0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .wr_hilo (wr_hilo),
        .cancel  (cancel),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic drive_idle();
        start   = 1'b0;
        wr_hilo = 1'b0;
        cancel  = 1'b0;
        md_op   = 3'd0;
        A       = 32'd0;
        B       = 32'd0;
    endtask

    // Called at posedge+1: present inputs for one edge, then return to idle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic w, input logic c);
        md_op   = op;
        A       = a;
        B       = b;
        start   = s;
        wr_hilo = w;
        cancel  = c;
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic push(input string nm, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        exp_t x;
        x.name = nm;
        x.hi   = hi;
        x.lo   = lo;
        x.cyc  = cyc;
        exp_q.push_back(x);
    endtask

    // Returns at posedge+1 of the first cycle with busy low.
    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (!busy) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: busy still 1 after 60 cycles, expected 0", nm);
        end
    endtask

    // Monitor: compare HI/LO and busy length whenever an operation completes.
    always @(negedge clk) begin
        if (reset) begin
            busy_prev = 1'b0;
            busy_len  = 0;
        end else begin
            if (busy) busy_len++;
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_completion: got HI=%h LO=%h with empty scoreboard", HI, LO);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_hi"}, HI, e.hi);
                    chk({e.name, "_lo"}, LO, e.lo);
                    chk({e.name, "_busy_cycles"}, 32'(busy_len), 32'(e.cyc));
                end
                busy_len = 0;
            end
            busy_prev = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset at the second busy cycle of a MULT aborts it.
        issue(MD_MULT, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_after_busy", 32'(busy), 32'd0);
        chk("rst_after_hi", HI, 32'd0);
        chk("rst_after_lo", LO, 32'd0);

        // MULT / MULTU of -2 * 3
        push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0);
        wait_idle("mult");
        push("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0);
        wait_idle("multu");

        // DIV -7 / 2
        push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
        wait_idle("div_neg");

        // Preload HI/LO, then DIVU by zero leaves them unchanged
        issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_busy", 32'(busy), 32'd0);
        issue(MD_MTLO, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("mtlo_lo", LO, 32'h1234_5678);
        push("divu_zero", 32'h1234_5678, 32'h1234_5678, 10);
        issue(MD_DIVU, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0);
        wait_idle("divu_zero");

        // Signed overflow case
        push("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        wait_idle("div_ovf");

        // Cancelled start, then MTLO
        issue(MD_MULT, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1);
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_hi", HI, 32'h0000_0000);
        chk("cancel_lo", LO, 32'h8000_0000);
        issue(MD_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("mtlo2_lo", LO, 32'hDEAD_BEEF);
        chk("mtlo2_hi", HI, 32'h0000_0000);
        chk("mtlo2_busy", 32'(busy), 32'd0);

        // start and wr_hilo during busy are ignored
        push("mult_ign", 32'h0000_0001, 32'h0000_0000, 5);
        issue(MD_MULT, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
        issue(MD_MTHI, 32'h0000_0BAD, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("ign_mthi_hi", HI, 32'h0000_0000);
        wait_idle("mult_ign");

        // Back-to-back: MULT issued in the first idle cycle after a DIV
        push("div_b2b", 32'h0000_0002, 32'h0000_000E, 10);
        issue(MD_DIV, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
        wait_idle("div_b2b");
        push("mult_b2b", 32'h0000_0000, 32'h0000_002A, 5);
        issue(MD_MULT, 32'd6, 32'd7, 1'b1, 1'b0, 1'b0);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_hold_hi", HI, 32'h0000_0002);
        chk("b2b_hold_lo", LO, 32'h0000_000E);
        wait_idle("mult_b2b");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
